// File: rtl/sumador_serie_ctrl_if.sv
// Handshake bundle for the bit-serial adder controller.
// The requester drives operands; the consumer takes the sum.
interface sumador_serie_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
endinterface

// File: rtl/sumador_serie_ctrl.sv
// Bit-serial adder controller: one full-adder cell sequenced LSB first over WIDTH cycles,
// carry kept in a register between bits, valid/ready handshakes on both sides.
module sumador_serie_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  sumador_serie_ctrl_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, sum_sh_q, sum_sh_d, sum_q;
  logic             c_q, c_d, s_bit;
  logic             cout_q, out_valid_q, in_ready_q, busy_q;

  always_comb begin
    s_bit              = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
    c_d                = (a_sh_q[0] & b_sh_q[0]) | (b_sh_q[0] & c_q) | (a_sh_q[0] & c_q);
    sum_sh_d           = sum_sh_q >> 1;
    sum_sh_d[WIDTH-1]  = s_bit;
  end

  // sum/cout are captured from the final bit's next-state so they stay put during RUN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_sh_q    <= '0;
      sum_q       <= '0;
      c_q         <= 1'b0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            a_sh_q     <= bus.a;
            b_sh_q     <= bus.b;
            c_q        <= bus.cin;
            cnt_q      <= '0;
            state_q    <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          c_q      <= c_d;
          sum_sh_q <= sum_sh_d;
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q     <= DONE;
            sum_q       <= sum_sh_d;
            cout_q      <= c_d;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q & ~rst;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_sumador_serie_ctrl.sv
// Bench for sumador_serie_ctrl: directed and random additions on an 8-bit instance
// against {cout,sum} = a+b+cin, plus a back-to-back truth-table sweep on a 1-bit instance.
module tb_sumador_serie_ctrl;
  logic clk;
  logic rst;
  int unsigned checks   = 0;
  int unsigned failures = 0;

  sumador_serie_ctrl_if #(.WIDTH(8)) if8 ();
  sumador_serie_ctrl_if #(.WIDTH(1)) if1 ();

  sumador_serie_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
  sumador_serie_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                      input int unsigned hold, input string tag);
    logic [8:0]  exp;
    int unsigned n;
    exp = 9'(a) + 9'(b) + 9'(ci);
    if8.a = a; if8.b = b; if8.cin = ci; if8.in_valid = 1'b1;
    n = 0;
    while (!if8.in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, " in_ready"}, 32'(if8.in_ready), 32'd1);
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
    if8.a = 8'($urandom); if8.b = 8'($urandom); if8.cin = 1'($urandom);
    n = 0;
    while (!if8.out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, " latency"}, n, 32'd8);
    chk({tag, " sum"}, 32'(if8.sum), 32'(exp[7:0]));
    chk({tag, " cout"}, 32'(if8.cout), 32'(exp[8]));
    chk({tag, " busy"}, 32'(if8.busy), 32'd1);
    for (int unsigned i = 0; i < hold; i++) begin
      if8.in_valid = 1'($urandom);
      if8.a = 8'($urandom); if8.b = 8'($urandom);
      @(posedge clk); #1;
      chk({tag, " hold"}, {22'd0, if8.out_valid, if8.in_ready, if8.cout, if8.sum},
          {22'd0, 1'b1, 1'b0, exp});
    end
    if8.in_valid  = 1'b0;
    if8.out_ready = 1'b1;
    @(posedge clk); #1;
    if8.out_ready = 1'b0;
    chk({tag, " handoff"}, {29'd0, if8.out_valid, if8.in_ready, if8.busy}, 32'b010);
    chk({tag, " idle hold"}, 32'({if8.cout, if8.sum}), 32'(exp));
  endtask

  logic [1:0]  q1[$];
  logic [1:0]  e1;
  int unsigned idx, done, cyc;

  initial begin
    rst = 1'b1;
    if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0; if8.out_ready = 1'b0;
    if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0; if1.out_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset outputs", {20'd0, if8.busy, if8.out_valid, if8.in_ready, if8.cout, if8.sum}, 32'd0);
    rst = 1'b0;
    #1;
    chk("reset in_ready", 32'(if8.in_ready), 32'd1);

    run8(8'h0F, 8'h01, 1'b0, 0, "basic");
    run8(8'hFF, 8'h01, 1'b0, 0, "wrap");
    run8(8'hFF, 8'hFF, 1'b1, 0, "max");
    run8(8'h5A, 8'h3C, 1'b1, 5, "backpressure");

    // Reset mid-RUN: everything clears within the same cycle
    if8.a = 8'hA5; if8.b = 8'h77; if8.cin = 1'b1; if8.in_valid = 1'b1;
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("midrun busy", 32'(if8.busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("midrun reset", {20'd0, if8.busy, if8.out_valid, if8.in_ready, if8.cout, if8.sum}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("post reset in_ready", {30'd0, if8.in_ready, if8.busy}, 32'b10);

    for (int unsigned i = 0; i < 24; i++)
      run8(8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 3), "rand");

    idx = 0; done = 0; cyc = 0;
    while (done < 8 && cyc < 300) begin
      if1.in_valid = (idx < 8);
      if1.a = 1'(idx); if1.b = 1'(idx >> 1); if1.cin = 1'(idx >> 2);
      if1.out_ready = ($urandom_range(0, 3) != 0);
      if (if1.out_valid && if1.out_ready) begin
        if (q1.size() == 0) chk("w1 unexpected result", 32'd1, 32'd0);
        else begin
          e1 = q1.pop_front();
          chk("w1 sum", 32'({if1.cout, if1.sum}), 32'(e1));
        end
        done++;
      end
      if (if1.in_valid && if1.in_ready) begin
        q1.push_back(2'(if1.a) + 2'(if1.b) + 2'(if1.cin));
        idx++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if1.in_valid = 1'b0;
    chk("w1 completed", done, 32'd8);
    chk("w1 accepted", idx, 32'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
